// File: rtl/id_ex_stage_if.sv
// Bundle between decode, the hazard/forwarding sources and the ID/EX stage.
// The master side drives decode fields and forwarding sources. The slave side returns the EX operands.
interface id_ex_stage_if #(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5
);
  logic                      stall;
  logic                      flush;
  logic [REG_ADDR_WIDTH-1:0] id_rs;
  logic [REG_ADDR_WIDTH-1:0] id_rt;
  logic [REG_ADDR_WIDTH-1:0] id_rd;
  logic [DATA_WIDTH-1:0]     id_rs_data;
  logic [DATA_WIDTH-1:0]     id_rt_data;
  logic [15:0]               id_imm16;
  logic                      id_zero_ext;
  logic                      id_alu_src;
  logic [3:0]                id_alu_control;
  logic                      id_reg_write;
  logic                      id_mem_read;
  logic                      id_mem_write;
  logic                      id_mem_to_reg;
  logic                      id_branch;
  logic                      id_branch_ne;
  logic                      exmem_reg_write;
  logic [REG_ADDR_WIDTH-1:0] exmem_rd;
  logic [DATA_WIDTH-1:0]     exmem_result;
  logic                      memwb_reg_write;
  logic [REG_ADDR_WIDTH-1:0] memwb_rd;
  logic [DATA_WIDTH-1:0]     memwb_result;
  logic [DATA_WIDTH-1:0]     dado_1;
  logic [DATA_WIDTH-1:0]     dado_2;
  logic [3:0]                ALUControl;
  logic [DATA_WIDTH-1:0]     store_data;
  logic [REG_ADDR_WIDTH-1:0] ex_rs;
  logic [REG_ADDR_WIDTH-1:0] ex_rt;
  logic [REG_ADDR_WIDTH-1:0] ex_rd;
  logic                      ex_reg_write;
  logic                      ex_mem_read;
  logic                      ex_mem_write;
  logic                      ex_mem_to_reg;
  logic                      ex_branch;
  logic                      ex_branch_ne;
  logic                      ex_valid;

  modport master (
    output stall, flush, id_rs, id_rt, id_rd, id_rs_data, id_rt_data, id_imm16,
           id_zero_ext, id_alu_src, id_alu_control, id_reg_write, id_mem_read,
           id_mem_write, id_mem_to_reg, id_branch, id_branch_ne,
           exmem_reg_write, exmem_rd, exmem_result,
           memwb_reg_write, memwb_rd, memwb_result,
    input  dado_1, dado_2, ALUControl, store_data, ex_rs, ex_rt, ex_rd,
           ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg,
           ex_branch, ex_branch_ne, ex_valid
  );

  modport slave (
    input  stall, flush, id_rs, id_rt, id_rd, id_rs_data, id_rt_data, id_imm16,
           id_zero_ext, id_alu_src, id_alu_control, id_reg_write, id_mem_read,
           id_mem_write, id_mem_to_reg, id_branch, id_branch_ne,
           exmem_reg_write, exmem_rd, exmem_result,
           memwb_reg_write, memwb_rd, memwb_result,
    output dado_1, dado_2, ALUControl, store_data, ex_rs, ex_rt, ex_rd,
           ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg,
           ex_branch, ex_branch_ne, ex_valid
  );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with immediate extension, write-through capture and
// EX/MEM / MEM/WB operand forwarding feeding the ALU.
module id_ex_stage #(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5
) (
  input logic         clock,
  input logic         reset,
  id_ex_stage_if.slave bus
);
  logic [REG_ADDR_WIDTH-1:0] rs_reg, rt_reg, rd_reg;
  logic [DATA_WIDTH-1:0]     rs_data_reg, rt_data_reg, imm_ext_reg;
  logic                      alu_src_reg, valid_reg;
  logic [3:0]                alu_control_reg;
  logic                      reg_write_reg, mem_read_reg, mem_write_reg;
  logic                      mem_to_reg_reg, branch_reg, branch_ne_reg;
  logic [DATA_WIDTH-1:0]     imm_ext_next;

  // Index 0 is the rs operand, index 1 is the rt operand.
  logic [REG_ADDR_WIDTH-1:0] id_src   [2];
  logic [REG_ADDR_WIDTH-1:0] ex_src   [2];
  logic [DATA_WIDTH-1:0]     id_data  [2];
  logic [DATA_WIDTH-1:0]     ex_data  [2];
  logic [DATA_WIDTH-1:0]     data_next[2];
  logic [DATA_WIDTH-1:0]     fwd      [2];

  assign id_src[0]  = bus.id_rs;
  assign id_src[1]  = bus.id_rt;
  assign id_data[0] = bus.id_rs_data;
  assign id_data[1] = bus.id_rt_data;
  assign ex_src[0]  = rs_reg;
  assign ex_src[1]  = rt_reg;
  assign ex_data[0] = rs_data_reg;
  assign ex_data[1] = rt_data_reg;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_operand
      // A register written back this very cycle is not yet visible in the register file read.
      assign data_next[gi] = (bus.memwb_reg_write && (bus.memwb_rd != '0) &&
                              (bus.memwb_rd == id_src[gi])) ? bus.memwb_result : id_data[gi];

      assign fwd[gi] = (bus.exmem_reg_write && (bus.exmem_rd != '0) &&
                        (bus.exmem_rd == ex_src[gi])) ? bus.exmem_result :
                       (bus.memwb_reg_write && (bus.memwb_rd != '0) &&
                        (bus.memwb_rd == ex_src[gi])) ? bus.memwb_result :
                       ex_data[gi];
    end
  endgenerate

  assign imm_ext_next = bus.id_zero_ext ? {{(DATA_WIDTH-16){1'b0}}, bus.id_imm16}
                                        : {{(DATA_WIDTH-16){bus.id_imm16[15]}}, bus.id_imm16};

  always_ff @(posedge clock) begin
    if (reset || bus.flush) begin
      rs_reg          <= '0;
      rt_reg          <= '0;
      rd_reg          <= '0;
      rs_data_reg     <= '0;
      rt_data_reg     <= '0;
      imm_ext_reg     <= '0;
      alu_src_reg     <= 1'b0;
      alu_control_reg <= 4'b0000;
      reg_write_reg   <= 1'b0;
      mem_read_reg    <= 1'b0;
      mem_write_reg   <= 1'b0;
      mem_to_reg_reg  <= 1'b0;
      branch_reg      <= 1'b0;
      branch_ne_reg   <= 1'b0;
      valid_reg       <= 1'b0;
    end else if (!bus.stall) begin
      rs_reg          <= bus.id_rs;
      rt_reg          <= bus.id_rt;
      rd_reg          <= bus.id_rd;
      rs_data_reg     <= data_next[0];
      rt_data_reg     <= data_next[1];
      imm_ext_reg     <= imm_ext_next;
      alu_src_reg     <= bus.id_alu_src;
      alu_control_reg <= bus.id_alu_control;
      reg_write_reg   <= bus.id_reg_write;
      mem_read_reg    <= bus.id_mem_read;
      mem_write_reg   <= bus.id_mem_write;
      mem_to_reg_reg  <= bus.id_mem_to_reg;
      branch_reg      <= bus.id_branch;
      branch_ne_reg   <= bus.id_branch_ne;
      valid_reg       <= 1'b1;
    end
  end

  // The store value is always the forwarded rt, even when the ALU takes the immediate.
  assign bus.dado_1        = fwd[0];
  assign bus.dado_2        = alu_src_reg ? imm_ext_reg : fwd[1];
  assign bus.store_data    = fwd[1];
  assign bus.ALUControl    = alu_control_reg;
  assign bus.ex_rs         = rs_reg;
  assign bus.ex_rt         = rt_reg;
  assign bus.ex_rd         = rd_reg;
  assign bus.ex_reg_write  = reg_write_reg;
  assign bus.ex_mem_read   = mem_read_reg;
  assign bus.ex_mem_write  = mem_write_reg;
  assign bus.ex_mem_to_reg = mem_to_reg_reg;
  assign bus.ex_branch     = branch_reg;
  assign bus.ex_branch_ne  = branch_ne_reg;
  assign bus.ex_valid      = valid_reg;
endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed vector table, stall/flush/reset
// sequences, then randomized traffic against a behavioural model.
module tb_id_ex_stage;
  logic clock;
  logic reset;
  int   total = 0;
  int   bad   = 0;

  id_ex_stage_if #(.DATA_WIDTH(32), .REG_ADDR_WIDTH(5)) bus ();

  id_ex_stage #(.DATA_WIDTH(32), .REG_ADDR_WIDTH(5)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        rst, stl, fl;
    logic [4:0]  rs, rt, rd;
    logic [31:0] rs_data, rt_data;
    logic [15:0] imm;
    logic        zext, asrc, rw;
    logic [3:0]  alu;
    logic        pwb_rw;  logic [4:0] pwb_rd;  logic [31:0] pwb_res;
    logic        em_rw;   logic [4:0] em_rd;   logic [31:0] em_res;
    logic        wb_rw;   logic [4:0] wb_rd;   logic [31:0] wb_res;
    logic [31:0] e_d1, e_d2, e_sd;
    logic [3:0]  e_alu;
    logic        e_valid, e_rw;
  } vec_t;

  function automatic vec_t blank();
    vec_t v;
    v = '{default: '0};
    return v;
  endfunction

  task automatic clear_inputs();
    reset = 0;
    bus.stall = 0; bus.flush = 0;
    bus.id_rs = 0; bus.id_rt = 0; bus.id_rd = 0;
    bus.id_rs_data = 0; bus.id_rt_data = 0; bus.id_imm16 = 0;
    bus.id_zero_ext = 0; bus.id_alu_src = 0; bus.id_alu_control = 0;
    bus.id_reg_write = 0; bus.id_mem_read = 0; bus.id_mem_write = 0;
    bus.id_mem_to_reg = 0; bus.id_branch = 0; bus.id_branch_ne = 0;
    bus.exmem_reg_write = 0; bus.exmem_rd = 0; bus.exmem_result = 0;
    bus.memwb_reg_write = 0; bus.memwb_rd = 0; bus.memwb_result = 0;
  endtask

  // Behavioural model: what the EX stage currently holds.
  typedef struct {
    logic        valid;
    logic [4:0]  rs, rt, rd;
    logic [31:0] rs_val, rt_val, imm;
    logic        asrc;
    logic [3:0]  alu;
    logic [5:0]  ctrl;
  } instr_t;
  instr_t m;

  function automatic logic [31:0] newest(input logic [4:0] r, input logic [31:0] held);
    // Youngest pending writer wins; register 0 is hardwired and never written.
    if (r == 0) return held;
    if (bus.exmem_reg_write && bus.exmem_rd == r) return bus.exmem_result;
    if (bus.memwb_reg_write && bus.memwb_rd == r) return bus.memwb_result;
    return held;
  endfunction

  function automatic logic [31:0] rf_read(input logic [4:0] r, input logic [31:0] raw);
    if (r != 0 && bus.memwb_reg_write && bus.memwb_rd == r) return bus.memwb_result;
    return raw;
  endfunction

  task automatic model_edge();
    if (reset || bus.flush) m = '{default: '0};
    else if (!bus.stall) begin
      m.valid  = 1;
      m.rs     = bus.id_rs;  m.rt = bus.id_rt;  m.rd = bus.id_rd;
      m.rs_val = rf_read(bus.id_rs, bus.id_rs_data);
      m.rt_val = rf_read(bus.id_rt, bus.id_rt_data);
      m.imm    = bus.id_zero_ext ? 32'(bus.id_imm16) : 32'(signed'(bus.id_imm16));
      m.asrc   = bus.id_alu_src;
      m.alu    = bus.id_alu_control;
      m.ctrl   = {bus.id_reg_write, bus.id_mem_read, bus.id_mem_write,
                  bus.id_mem_to_reg, bus.id_branch, bus.id_branch_ne};
    end
  endtask

  vec_t tbl[12];

  initial begin
    clear_inputs();
    // 0: reset state, checked after reset is released
    tbl[0] = blank(); tbl[0].rst = 1;
    // 1: plain register operands
    tbl[1] = blank(); tbl[1].rs = 8; tbl[1].rs_data = 5; tbl[1].rt = 9; tbl[1].rt_data = 3;
    tbl[1].alu = 4'b0110; tbl[1].rw = 1;
    tbl[1].e_d1 = 5; tbl[1].e_d2 = 3; tbl[1].e_sd = 3; tbl[1].e_alu = 4'b0110; tbl[1].e_valid = 1; tbl[1].e_rw = 1;
    // 2/3: sign and zero extension of 0xFFFC
    tbl[2] = tbl[1]; tbl[2].imm = 16'hFFFC; tbl[2].asrc = 1; tbl[2].e_d2 = 32'hFFFF_FFFC;
    tbl[3] = tbl[2]; tbl[3].zext = 1; tbl[3].e_d2 = 32'h0000_FFFC;
    // 4: EX/MEM beats MEM/WB
    tbl[4] = tbl[1]; tbl[4].rs_data = 1;
    tbl[4].em_rw = 1; tbl[4].em_rd = 8; tbl[4].em_res = 32'hAA;
    tbl[4].wb_rw = 1; tbl[4].wb_rd = 8; tbl[4].wb_res = 32'hBB; tbl[4].e_d1 = 32'hAA;
    // 5: EX/MEM not writing, MEM/WB forwards
    tbl[5] = tbl[4]; tbl[5].em_rw = 0; tbl[5].e_d1 = 32'hBB;
    // 6: register 0 never forwarded
    tbl[6] = tbl[1]; tbl[6].rs = 0; tbl[6].rs_data = 32'h77;
    tbl[6].em_rw = 1; tbl[6].em_rd = 0; tbl[6].em_res = 32'hAA;
    tbl[6].wb_rw = 1; tbl[6].wb_rd = 0; tbl[6].wb_res = 32'hBB; tbl[6].e_d1 = 32'h77;
    // 7: write-through on rt at capture
    tbl[7] = tbl[1]; tbl[7].rt_data = 32'h11;
    tbl[7].pwb_rw = 1; tbl[7].pwb_rd = 9; tbl[7].pwb_res = 32'h22; tbl[7].e_d2 = 32'h22; tbl[7].e_sd = 32'h22;
    // 8: no write-through into register 0
    tbl[8] = tbl[7]; tbl[8].rt = 0; tbl[8].pwb_rd = 0; tbl[8].e_d2 = 32'h11; tbl[8].e_sd = 32'h11;
    // 9: write-through on rs at capture
    tbl[9] = tbl[1]; tbl[9].rs = 5; tbl[9].rs_data = 32'h10;
    tbl[9].pwb_rw = 1; tbl[9].pwb_rd = 5; tbl[9].pwb_res = 32'h99; tbl[9].e_d1 = 32'h99;
    // 10: flush with a valid instruction present loads a bubble
    tbl[10] = tbl[1]; tbl[10].fl = 1;
    tbl[10].e_d1 = 0; tbl[10].e_d2 = 0; tbl[10].e_sd = 0; tbl[10].e_alu = 0; tbl[10].e_valid = 0; tbl[10].e_rw = 0;
    // 11: store_data forwarded while dado_2 takes the immediate
    tbl[11] = tbl[1]; tbl[11].asrc = 1; tbl[11].imm = 16'h0010;
    tbl[11].em_rw = 1; tbl[11].em_rd = 9; tbl[11].em_res = 32'hAA;
    tbl[11].wb_rw = 1; tbl[11].wb_rd = 9; tbl[11].wb_res = 32'hBB;
    tbl[11].e_d2 = 32'h10; tbl[11].e_sd = 32'hAA;

    for (int i = 0; i < 12; i++) begin
      reset = tbl[i].rst; bus.stall = tbl[i].stl; bus.flush = tbl[i].fl;
      bus.id_rs = tbl[i].rs; bus.id_rt = tbl[i].rt; bus.id_rd = tbl[i].rd;
      bus.id_rs_data = tbl[i].rs_data; bus.id_rt_data = tbl[i].rt_data;
      bus.id_imm16 = tbl[i].imm; bus.id_zero_ext = tbl[i].zext; bus.id_alu_src = tbl[i].asrc;
      bus.id_alu_control = tbl[i].alu; bus.id_reg_write = tbl[i].rw;
      bus.memwb_reg_write = tbl[i].pwb_rw; bus.memwb_rd = tbl[i].pwb_rd; bus.memwb_result = tbl[i].pwb_res;
      bus.exmem_reg_write = 0; bus.exmem_rd = 0; bus.exmem_result = 0;
      @(posedge clock); #1;
      reset = 0; bus.stall = 0; bus.flush = 0;
      bus.exmem_reg_write = tbl[i].em_rw; bus.exmem_rd = tbl[i].em_rd; bus.exmem_result = tbl[i].em_res;
      bus.memwb_reg_write = tbl[i].wb_rw; bus.memwb_rd = tbl[i].wb_rd; bus.memwb_result = tbl[i].wb_res;
      #1;
      chk($sformatf("vec%0d dado_1", i), bus.dado_1, tbl[i].e_d1);
      chk($sformatf("vec%0d dado_2", i), bus.dado_2, tbl[i].e_d2);
      chk($sformatf("vec%0d store_data", i), bus.store_data, tbl[i].e_sd);
      chk($sformatf("vec%0d ALUControl", i), 32'(bus.ALUControl), 32'(tbl[i].e_alu));
      chk($sformatf("vec%0d ex_valid", i), 32'(bus.ex_valid), 32'(tbl[i].e_valid));
      chk($sformatf("vec%0d ex_reg_write", i), 32'(bus.ex_reg_write), 32'(tbl[i].e_rw));
      $display("vec %0d: dado_1=%h dado_2=%h store_data=%h valid=%b", i,
               bus.dado_1, bus.dado_2, bus.store_data, bus.ex_valid);
    end

    // Stall holds instruction A, flush+stall bubbles it, reset mid-stall bubbles it.
    for (int pass = 0; pass < 2; pass++) begin
      clear_inputs();
      bus.id_rs = 3; bus.id_rs_data = 32'h1234; bus.id_rt = 4; bus.id_rt_data = 32'h5678;
      bus.id_alu_control = 4'b0010; bus.id_reg_write = 1; bus.id_mem_write = 1;
      @(posedge clock); #1;
      for (int k = 0; k < 3; k++) begin
        bus.stall = 1;
        bus.id_rs = 5'($urandom_range(1, 31)); bus.id_rs_data = $urandom;
        bus.id_rt = 5'($urandom_range(1, 31)); bus.id_rt_data = $urandom;
        bus.id_alu_control = 4'($urandom); bus.id_mem_write = 0; bus.id_reg_write = 0;
        @(posedge clock); #1;
        chk($sformatf("stall%0d dado_1", k), bus.dado_1, 32'h1234);
        chk($sformatf("stall%0d dado_2", k), bus.dado_2, 32'h5678);
        chk($sformatf("stall%0d ALUControl", k), 32'(bus.ALUControl), 32'h2);
        chk($sformatf("stall%0d ex_mem_write", k), 32'(bus.ex_mem_write), 32'h1);
        $display("stall cycle %0d: dado_1=%h dado_2=%h", k, bus.dado_1, bus.dado_2);
      end
      bus.exmem_reg_write = 1; bus.exmem_rd = 3; bus.exmem_result = 32'hCAFE; #1;
      chk("stall fwd dado_1", bus.dado_1, 32'hCAFE);
      bus.exmem_reg_write = 0;
      if (pass == 0) bus.flush = 1; else reset = 1;
      @(posedge clock); #1;
      reset = 0; bus.flush = 0; bus.stall = 0;
      chk("bubble ex_valid", 32'(bus.ex_valid), 32'h0);
      chk("bubble ex_reg_write", 32'(bus.ex_reg_write), 32'h0);
      chk("bubble ex_mem_write", 32'(bus.ex_mem_write), 32'h0);
      chk("bubble dado_1", bus.dado_1, 32'h0);
      $display("bubble after %s: valid=%b", pass == 0 ? "flush+stall" : "reset+stall", bus.ex_valid);
    end

    // Randomized traffic against the behavioural model.
    clear_inputs();
    reset = 1;
    @(posedge clock); model_edge(); #1;
    for (int c = 0; c < 400; c++) begin
      reset = ($urandom_range(0, 29) == 0);
      bus.flush = ($urandom_range(0, 9) == 0);
      bus.stall = ($urandom_range(0, 4) == 0);
      bus.id_rs = 5'($urandom_range(0, 3)); bus.id_rt = 5'($urandom_range(0, 3));
      bus.id_rd = 5'($urandom); bus.id_rs_data = $urandom; bus.id_rt_data = $urandom;
      bus.id_imm16 = 16'($urandom); bus.id_zero_ext = 1'($urandom); bus.id_alu_src = 1'($urandom);
      bus.id_alu_control = 4'($urandom);
      {bus.id_reg_write, bus.id_mem_read, bus.id_mem_write,
       bus.id_mem_to_reg, bus.id_branch, bus.id_branch_ne} = 6'($urandom);
      bus.exmem_reg_write = 1'($urandom); bus.exmem_rd = 5'($urandom_range(0, 3)); bus.exmem_result = $urandom;
      bus.memwb_reg_write = 1'($urandom); bus.memwb_rd = 5'($urandom_range(0, 3)); bus.memwb_result = $urandom;
      #2;
      chk("rand dado_1", bus.dado_1, newest(m.rs, m.rs_val));
      chk("rand dado_2", bus.dado_2, m.asrc ? m.imm : newest(m.rt, m.rt_val));
      chk("rand store_data", bus.store_data, newest(m.rt, m.rt_val));
      chk("rand ALUControl", 32'(bus.ALUControl), 32'(m.alu));
      chk("rand ex_valid", 32'(bus.ex_valid), 32'(m.valid));
      chk("rand specifiers", 32'({bus.ex_rs, bus.ex_rt, bus.ex_rd}), 32'({m.rs, m.rt, m.rd}));
      chk("rand control", 32'({bus.ex_reg_write, bus.ex_mem_read, bus.ex_mem_write,
                               bus.ex_mem_to_reg, bus.ex_branch, bus.ex_branch_ne}), 32'(m.ctrl));
      $display("rand %0d: rst=%b fl=%b st=%b dado_1=%h dado_2=%h valid=%b", c, reset,
               bus.flush, bus.stall, bus.dado_1, bus.dado_2, bus.ex_valid);
      @(posedge clock); model_edge(); #1;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
